// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: command sequencer in front of an 8-bit shift register that
// has no hold code and no reset. Takes one command (op, data, repeat count)
// over valid/ready, drives sr_ctl/sr_din for the required cycles, then
// returns the register contents over a response handshake.
//
// Optional build macro: SHIFT_CMD_SEQ_B2B_EN
//   defined   - a new command may be accepted in RESP on the same edge the
//               response is consumed (back-to-back, no IDLE cycle)
//   undefined - RESP always returns to IDLE before the next command
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | hold register, cmd_ready high, wait for a command
// EXEC    | drive latched op on sr_ctl for N cycles
// CAPTURE | one hold cycle, sample sr_dout into rsp_data at its end
// RESP    | hold register, present response until rsp_ready
module shift_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [2:0]       sr_ctl,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_RSVD  = 3'b101;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic             w_cmd_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_n;
  logic [2:0]       w_ctl;
  logic [WIDTH-1:0] w_din;

  // Number of EXEC cycles the offered command needs.
  always_comb begin
    w_n = cmd_cnt;
    case (cmd_op)
      OP_CLEAR, OP_LOAD: w_n = CNT_W'(1);
      OP_RSVD:           w_n = '0;
      default:           w_n = cmd_cnt;
    endcase
  end

  // Command acceptance; held low while in reset.
  always_comb begin
    w_cmd_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: w_cmd_ready = 1'b1;
`ifdef SHIFT_CMD_SEQ_B2B_EN
        S_RESP: w_cmd_ready = rsp_ready;
`endif
        default: w_cmd_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = cmd_valid & w_cmd_ready;

  // Shift register drive: clear during reset, latched op in EXEC, and
  // otherwise a load of its own output, which is how hold is emulated.
  always_comb begin
    w_ctl = OP_LOAD;
    w_din = sr_dout;
    if (!rst_n) begin
      w_ctl = OP_CLEAR;
      w_din = '0;
    end else if (r_state == S_EXEC) begin
      w_ctl = r_op;
      w_din = (r_op == OP_LOAD) ? r_data : '0;
    end
  end

  // Sequencer state, repeat counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_CLEAR;
      r_data      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_EXEC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_data  <= sr_dout;
          r_rsp_err   <= r_err;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Acceptance (IDLE, or RESP in back-to-back builds) overrides the
      // state update above. Op 101 gets N=0 so it never reaches sr_ctl.
      if (w_accept) begin
        r_op    <= cmd_op;
        r_data  <= cmd_data;
        r_cnt   <= w_n;
        r_err   <= (cmd_op == OP_RSVD);
        r_state <= (w_n != '0) ? S_EXEC : S_CAPTURE;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign sr_ctl    = w_ctl;
  assign sr_din    = w_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq with a behavioural model of the
// downstream 8-bit shift register (no reset, no hold code).
module tb_shift_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] cmd_cnt;
  logic [2:0] sr_ctl;
  logic [7:0] sr_din;
  logic [7:0] sr_dout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int ctl_hits [8];

  shift_cmd_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .sr_ctl(sr_ctl), .sr_din(sr_din), .sr_dout(sr_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift register model.
  always_ff @(posedge clk) begin
    case (sr_ctl)
      3'b000: sr_dout <= 8'h00;
      3'b001: sr_dout <= sr_din;
      3'b010: sr_dout <= {sr_dout[0], sr_dout[7:1]};
      3'b011: sr_dout <= {sr_dout[6:0], sr_dout[7]};
      3'b100: sr_dout <= {sr_dout[7], sr_dout[7:1]};
      3'b110: sr_dout <= {sr_dout[0] ^ sr_dout[2] ^ sr_dout[3] ^ sr_dout[4], sr_dout[7:1]};
      3'b111: sr_dout <= {sr_dout[6:0], sr_dout[7] ^ sr_dout[5] ^ sr_dout[4] ^ sr_dout[3]};
      default: sr_dout <= sr_dout;
    endcase
  end

  // Count which ctl codes are driven outside reset.
  always @(negedge clk) begin
    if (rst_n) ctl_hits[sr_ctl] = ctl_hits[sr_ctl] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until rsp_valid, bounded.
  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic consume(input string tag, input logic [7:0] exp_data);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".vld_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".err_clr"}, 32'(rsp_err), 32'd0);
    chk({tag, ".data_kept"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                         input logic [3:0] cnt, input int exp_lat, input logic [7:0] exp_data,
                         input logic exp_err, input int bp);
    int k;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    wait_rsp(k);
    chk({tag, ".lat"}, 32'(k), 32'(exp_lat));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, ".bp_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".bp_data"}, 32'(rsp_data), 32'(exp_data));
      chk({tag, ".bp_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, ".bp_dout"}, 32'(sr_dout), 32'(exp_data));
      chk({tag, ".bp_rdy"}, 32'(cmd_ready), 32'd0);
      chk({tag, ".bp_busy"}, 32'(busy), 32'd1);
    end
    consume(tag, exp_data);
  endtask

  initial begin
    int h;
    int k;
    foreach (ctl_hits[i]) ctl_hits[i] = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 8'h00;
    cmd_cnt   = 4'd0;
    rsp_ready = 1'b0;

    // Reset: register cleared, everything quiet.
    repeat (3) begin
      tick();
      chk("rst.ctl", 32'(sr_ctl), 32'd0);
      chk("rst.din", 32'(sr_din), 32'd0);
      chk("rst.ready", 32'(cmd_ready), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.vld", 32'(rsp_valid), 32'd0);
      chk("rst.data", 32'(rsp_data), 32'd0);
    end
    chk("rst.dout", 32'(sr_dout), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle.ctl", 32'(sr_ctl), 32'd1);
    chk("idle.din", 32'(sr_din), 32'd0);
    chk("idle.ready", 32'(cmd_ready), 32'd1);
    chk("idle.busy", 32'(busy), 32'd0);
    repeat (10) tick();
    chk("idle.dout", 32'(sr_dout), 32'd0);

    // Load with backpressure, then rotate right.
    run_cmd("load_a5", 3'b001, 8'hA5, 4'd0, 2, 8'hA5, 1'b0, 5);
    run_cmd("load_81", 3'b001, 8'h81, 4'd9, 2, 8'h81, 1'b0, 0);
    run_cmd("rotr3",   3'b010, 8'hFF, 4'd3, 4, 8'h30, 1'b0, 0);

    // Arithmetic shift, then a zero-count shift that must not touch sr_ctl.
    run_cmd("load_80", 3'b001, 8'h80, 4'd0, 2, 8'h80, 1'b0, 0);
    run_cmd("asr2",    3'b100, 8'h00, 4'd2, 3, 8'hE0, 1'b0, 0);
    h = ctl_hits[3];
    run_cmd("rotl0",   3'b011, 8'h00, 4'd0, 1, 8'hE0, 1'b0, 0);
    chk("rotl0.no_ctl", 32'(ctl_hits[3] - h), 32'd0);

    // Clear ignores the count; maximum repeat count.
    run_cmd("clr",     3'b000, 8'hFF, 4'd7, 2, 8'h00, 1'b0, 0);
    run_cmd("load_01", 3'b001, 8'h01, 4'd0, 2, 8'h01, 1'b0, 0);
    run_cmd("rotl15",  3'b011, 8'h00, 4'd15, 16, 8'h80, 1'b0, 0);

    // Reserved op: error response, register untouched.
    run_cmd("load_3c", 3'b001, 8'h3C, 4'd0, 2, 8'h3C, 1'b0, 0);
    h = ctl_hits[5];
    run_cmd("rsvd",    3'b101, 8'hFF, 4'd9, 1, 8'h3C, 1'b1, 2);
    chk("rsvd.no_ctl", 32'(ctl_hits[5] - h), 32'd0);

    // Reset in the middle of a long command aborts it.
    cmd_valid = 1'b1;
    cmd_op    = 3'b011;
    cmd_cnt   = 4'd15;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("abort.running", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.vld", 32'(rsp_valid), 32'd0);
    chk("abort.ctl", 32'(sr_ctl), 32'd0);
    chk("abort.ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("abort.dout", 32'(sr_dout), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort.idle_rdy", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort.dout_kept", 32'(sr_dout), 32'd0);

    // New command offered while the response is consumed.
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 8'h11;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(k);
    chk("b2b.first_lat", 32'(k), 32'd2);
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 8'h5A;
    rsp_ready = 1'b1;
    #1;
`ifdef SHIFT_CMD_SEQ_B2B_EN
    chk("b2b.ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b.vld_clr", 32'(rsp_valid), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.ctl", 32'(sr_ctl), 32'd1);
    chk("b2b.din", 32'(sr_din), 32'h5A);
`else
    chk("seq.ready", 32'(cmd_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    chk("seq.vld_clr", 32'(rsp_valid), 32'd0);
    chk("seq.idle", 32'(busy), 32'd0);
    chk("seq.idle_rdy", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("seq.busy", 32'(busy), 32'd1);
    chk("seq.din", 32'(sr_din), 32'h5A);
`endif
    wait_rsp(k);
    chk("b2b.second_lat", 32'(k), 32'd2);
    chk("b2b.data", 32'(rsp_data), 32'h5A);
    consume("b2b.end", 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
